// File: rtl/inst_encode_loader.sv
// Encodes decoded RV32I field bundles into 32-bit instruction words and
// streams them into the instruction ROM write port at consecutive addresses.
module inst_encode_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          DEPTH     = 4096,
  parameter int          CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    in_fmt,
  input  logic [6:0]    in_opcode,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          rom_wen,
  output logic [31:0]   rom_waddr,
  output logic [31:0]   rom_wdata,
  output logic [CW-1:0] word_count,
  output logic          done,
  output logic          err,
  output logic          err_flag
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wen_q, wen_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          errFlag_q, errFlag_d;

  logic [31:0] encWord;
  logic        encLegal;
  logic        isShift;
  logic        accept;

  assign in_ready   = (state_q == LOAD);
  assign accept     = in_valid & in_ready;
  assign isShift    = (in_opcode == 7'b0010011) &&
                      ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign rom_wen    = wen_q;
  assign rom_waddr  = waddr_q;
  assign rom_wdata  = wdata_q;
  assign word_count = count_q;
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign err_flag   = errFlag_q;

  // Immediate legality means the value fits the format's field after sign extension.
  always_comb begin
    encWord  = 32'd0;
    encLegal = 1'b0;
    case (in_fmt)
      3'd0: begin
        encWord  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        encLegal = 1'b1;
      end
      3'd1: begin
        if (isShift) begin
          encWord  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          encLegal = (in_imm[31:5] == 27'd0);
        end else begin
          encWord  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          encLegal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
        end
      end
      3'd2: begin
        encWord  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        encLegal = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      3'd3: begin
        encWord  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        encLegal = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
      end
      3'd4: begin
        encWord  = {in_imm[31:12], in_rd, in_opcode};
        encLegal = (in_imm[11:0] == 12'd0);
      end
      3'd5: begin
        encWord  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        encLegal = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
      end
      default: begin
        encWord  = 32'd0;
        encLegal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    errFlag_d = errFlag_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (encLegal) begin
            wen_d   = 1'b1;
            waddr_d = ptr_q;
            wdata_d = encWord;
            ptr_d   = ptr_q + 32'd4;
            count_d = count_q + 1'b1;
            if (count_q == CW'(DEPTH - 1)) begin
              state_d = DONE;
            end
          end else begin
            err_d     = 1'b1;
            errFlag_d = 1'b1;
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d   = LOAD;
          ptr_d     = BASE_ADDR;
          count_d   = '0;
          errFlag_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 32'd0;
      count_q   <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= 32'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      errFlag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      errFlag_q <= errFlag_d;
    end
  end

endmodule

// File: tb/tb_inst_encode_loader.sv
// Scoreboard bench for inst_encode_loader: a session-level reference model
// queues expected ROM writes / error pulses, a monitor checks them cycle by cycle.
module tb_inst_encode_loader;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = 32'd0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [2:0]    in_fmt = 3'd0;
  logic [6:0]    in_opcode = 7'd0;
  logic [2:0]    in_funct3 = 3'd0;
  logic [6:0]    in_funct7 = 7'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_rs1 = 5'd0;
  logic [4:0]    in_rs2 = 5'd0;
  logic [31:0]   in_imm = 32'd0;
  logic          rom_wen;
  logic [31:0]   rom_waddr;
  logic [31:0]   rom_wdata;
  logic [CW-1:0] word_count;
  logic          done;
  logic          err;
  logic          err_flag;

  inst_encode_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .rom_wen(rom_wen), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .word_count(word_count), .done(done), .err(err), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        isErr;
    logic [31:0] addr;
    logic [31:0] data;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  // Model session state: 0 idle, 1 loading, 2 finished
  int          mState = 0;
  int          mCount = 0;
  logic [31:0] mPtr = 32'd0;
  logic        mErrFlag = 1'b0;
  logic [31:0] mLastAddr = 32'd0;
  logic [31:0] mLastData = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit fitsSigned(input logic [31:0] v, input int bits);
    longint s;
    s = longint'($signed(v));
    return (s >= -(64'sd1 <<< (bits - 1))) && (s < (64'sd1 <<< (bits - 1)));
  endfunction

  function automatic bit refIsShift();
    return (in_opcode == 7'h13) && (in_funct3 == 3'd1 || in_funct3 == 3'd5);
  endfunction

  function automatic bit refLegal();
    case (in_fmt)
      3'd0: return 1'b1;
      3'd1: return refIsShift() ? (in_imm < 32) : fitsSigned(in_imm, 12);
      3'd2: return fitsSigned(in_imm, 12);
      3'd3: return fitsSigned(in_imm, 13) && (in_imm % 2 == 0);
      3'd4: return (in_imm % 4096) == 0;
      3'd5: return fitsSigned(in_imm, 21) && (in_imm % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refEncode();
    logic [31:0] i;
    i = in_imm;
    case (in_fmt)
      3'd0: return {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: return refIsShift() ? {in_funct7, i[4:0], in_rs1, in_funct3, in_rd, in_opcode}
                                : {i[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'd2: return {i[11:5], in_rs2, in_rs1, in_funct3, i[4:0], in_opcode};
      3'd3: return {i[12], i[10:5], in_rs2, in_rs1, in_funct3, i[4:1], i[11], in_opcode};
      3'd4: return {i[31:12], in_rd, in_opcode};
      3'd5: return {i[20], i[10:1], i[11], i[19:12], in_rd, in_opcode};
      default: return 32'd0;
    endcase
  endfunction

  task automatic setBundle(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // One clock cycle: drive, check visible session status, then advance the model at the edge.
  task automatic applyStimulus(input logic rstV, input logic startV, input logic validV,
                               input logic lastV, input logic useConst,
                               input logic [31:0] constWord);
    expT e;
    rst = rstV; start = startV; in_valid = validV; in_last = lastV;
    @(negedge clk);
    checkOutput("inReady", in_ready, mState == 1);
    checkOutput("done", done, mState == 2);
    checkOutput("wordCount", word_count, mCount);
    checkOutput("errFlag", err_flag, mErrFlag);
    @(posedge clk);
    if (rstV) begin
      mState = 0; mCount = 0; mPtr = 32'd0; mErrFlag = 1'b0;
      mLastAddr = 32'd0; mLastData = 32'd0;
    end else if (mState == 1) begin
      if (validV) begin
        if (refLegal()) begin
          e.isErr = 1'b0; e.addr = mPtr;
          e.data = useConst ? constWord : refEncode();
          expQ.push_back(e);
          mLastAddr = e.addr; mLastData = e.data;
          mPtr += 4; mCount++;
          if (mCount == DEPTH) mState = 2;
        end else begin
          e.isErr = 1'b1; e.addr = 32'd0; e.data = 32'd0;
          expQ.push_back(e);
          mErrFlag = 1'b1;
        end
        if (lastV) mState = 2;
      end
    end else if (startV) begin
      mState = 1; mPtr = BASE; mCount = 0; mErrFlag = 1'b0;
    end
    #1;
  endtask

  always @(negedge clk) begin
    expT e;
    if (rom_wen || err) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousEvent", {30'd0, rom_wen, err}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("eventKind", {30'd0, rom_wen, err}, e.isErr ? 32'd1 : 32'd2);
        if (!e.isErr) begin
          checkOutput("romWaddr", rom_waddr, e.addr);
          checkOutput("romWdata", rom_wdata, e.data);
        end
      end
    end else begin
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("missingEvent", 32'd0, e.isErr ? 32'd1 : 32'd2);
      end
      checkOutput("heldWaddr", rom_waddr, mLastAddr);
      checkOutput("heldWdata", rom_wdata, mLastData);
    end
  end

  task automatic randomBundle();
    logic [31:0] r;
    r = $urandom;
    setBundle($urandom_range(0, 9) == 0 ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5)),
              7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), r);
    if (in_fmt == 3'd1 && $urandom_range(0, 2) == 0) begin
      in_opcode = 7'h13;
      in_funct3 = $urandom_range(0, 1) ? 3'd1 : 3'd5;
    end
    if ($urandom_range(0, 3) != 0) begin
      case (in_fmt)
        3'd1: in_imm = refIsShift() ? (r & 32'h1F) : 32'($signed(r) >>> 20);
        3'd2: in_imm = 32'($signed(r) >>> 20);
        3'd3: in_imm = 32'($signed(r) >>> 19) & ~32'd1;
        3'd4: in_imm = r & 32'hFFFFF000;
        3'd5: in_imm = 32'($signed(r) >>> 11) & ~32'd1;
        default: in_imm = r;
      endcase
    end
  endtask

  initial begin
    setBundle(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Three back-to-back bundles with known encodings, last on the third
    applyStimulus(0, 1, 0, 0, 0, 0);
    setBundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    applyStimulus(0, 0, 1, 0, 1, 32'h00500093);
    setBundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8);
    applyStimulus(0, 0, 1, 0, 1, 32'hFE208CE3);
    setBundle(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    applyStimulus(0, 0, 1, 1, 1, 32'h123452B7);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Illegal J immediate, then a legal word at the unchanged address
    applyStimulus(0, 1, 0, 0, 0, 0);
    setBundle(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    setBundle(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
    applyStimulus(0, 1, 1, 1, 1, 32'h402081B3);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Offer six bundles; only DEPTH are accepted
    setBundle(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'hFFFFF800);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Reset colliding with an accept, and reset right after an accept
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      randomBundle();
      applyStimulus($urandom_range(0, 99) < 2,
                    (mState != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0, 0);
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("queueDrained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
